// File: rtl/measure_pkg.sv
// Shared types and constants for the frequency-measurement run controller.
// Result word layout is {ref_sum, sig_sum}, each CNT_W bits wide.
package measure_pkg;

  localparam int CNT_W   = 32;
  localparam int SIG_LSB = 0;
  localparam int REF_LSB = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GATE     = 2'd1,
    WAIT_RES = 2'd2,
    OUT      = 2'd3
  } seq_state_t;

endpackage

// File: rtl/measure_seq.sv
// Run controller: opens the measurement gate for G cycles, sums N datapath results,
// and offers the summed result on a valid/ready port (one-shot or continuous).
module measure_seq #(
  parameter int CNT_W = 32,
  parameter int RUN_W = 8,
  parameter int ACC_W = CNT_W + RUN_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_start_i,
  input  logic               cfg_stop_i,
  input  logic               cfg_cont_i,
  input  logic [31:0]        cfg_gate_time_i,
  input  logic [RUN_W-1:0]   cfg_runs_i,
  input  logic [31:0]        cfg_timeout_i,
  output logic               meas_gate_en_o,
  input  logic               meas_wr_en_i,
  input  logic [2*CNT_W-1:0] meas_wr_data_i,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic [ACC_W-1:0]   res_sig_o,
  output logic [ACC_W-1:0]   res_ref_o,
  output logic [RUN_W-1:0]   res_runs_o,
  output logic               busy_o,
  output logic               timeout_o
);
  import measure_pkg::*;

  seq_state_t       state_q, state_d;
  logic [31:0]      gate_cnt_q, gate_cnt_d;
  logic [31:0]      to_cnt_q, to_cnt_d;
  logic [31:0]      gate_lim_q, gate_lim_d;
  logic [31:0]      to_lim_q, to_lim_d;
  logic [RUN_W-1:0] runs_lim_q, runs_lim_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic [ACC_W-1:0] acc_sig_q, acc_sig_d;
  logic [ACC_W-1:0] acc_ref_q, acc_ref_d;
  logic             cont_q, cont_d;
  logic             stop_pend_q, stop_pend_d;
  logic             timeout_q, timeout_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      gate_cnt_q  <= '0;
      to_cnt_q    <= '0;
      gate_lim_q  <= '0;
      to_lim_q    <= '0;
      runs_lim_q  <= '0;
      run_cnt_q   <= '0;
      acc_sig_q   <= '0;
      acc_ref_q   <= '0;
      cont_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gate_cnt_q  <= gate_cnt_d;
      to_cnt_q    <= to_cnt_d;
      gate_lim_q  <= gate_lim_d;
      to_lim_q    <= to_lim_d;
      runs_lim_q  <= runs_lim_d;
      run_cnt_q   <= run_cnt_d;
      acc_sig_q   <= acc_sig_d;
      acc_ref_q   <= acc_ref_d;
      cont_q      <= cont_d;
      stop_pend_q <= stop_pend_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gate_cnt_d  = gate_cnt_q;
    to_cnt_d    = to_cnt_q;
    gate_lim_d  = gate_lim_q;
    to_lim_d    = to_lim_q;
    runs_lim_d  = runs_lim_q;
    run_cnt_d   = run_cnt_q;
    acc_sig_d   = acc_sig_q;
    acc_ref_d   = acc_ref_q;
    cont_d      = cont_q;
    stop_pend_d = stop_pend_q;
    timeout_d   = timeout_q;

    case (state_q)
      IDLE: begin
        if (cfg_start_i && !cfg_stop_i) begin
          state_d     = GATE;
          gate_cnt_d  = '0;
          run_cnt_d   = '0;
          acc_sig_d   = '0;
          acc_ref_d   = '0;
          timeout_d   = 1'b0;
          stop_pend_d = 1'b0;
          cont_d      = cfg_cont_i;
          to_lim_d    = cfg_timeout_i;
          gate_lim_d  = (cfg_gate_time_i == '0) ? 32'd1 : cfg_gate_time_i;
          runs_lim_d  = (cfg_runs_i == '0) ? RUN_W'(1) : cfg_runs_i;
        end
      end

      GATE: begin
        if (cfg_stop_i) begin
          state_d   = IDLE;
          run_cnt_d = '0;
          acc_sig_d = '0;
          acc_ref_d = '0;
        end else if (gate_cnt_q == gate_lim_q - 32'd1) begin
          state_d  = WAIT_RES;
          to_cnt_d = '0;
        end else begin
          gate_cnt_d = gate_cnt_q + 32'd1;
        end
      end

      WAIT_RES: begin
        // A strobe on the timeout cycle still counts: the result did arrive in time.
        if (cfg_stop_i) begin
          state_d   = IDLE;
          run_cnt_d = '0;
          acc_sig_d = '0;
          acc_ref_d = '0;
        end else if (meas_wr_en_i) begin
          acc_sig_d = acc_sig_q + ACC_W'(meas_wr_data_i[SIG_LSB +: CNT_W]);
          acc_ref_d = acc_ref_q + ACC_W'(meas_wr_data_i[REF_LSB +: CNT_W]);
          run_cnt_d = run_cnt_q + RUN_W'(1);
          if ((run_cnt_q + RUN_W'(1)) == runs_lim_q) begin
            state_d = OUT;
          end else begin
            state_d    = GATE;
            gate_cnt_d = '0;
          end
        end else if ((to_lim_q != '0) && (to_cnt_q == to_lim_q - 32'd1)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
          run_cnt_d = '0;
          acc_sig_d = '0;
          acc_ref_d = '0;
        end else if (to_cnt_q != '1) begin
          to_cnt_d = to_cnt_q + 32'd1;
        end
      end

      OUT: begin
        if (cfg_stop_i) stop_pend_d = 1'b1;
        if (res_ready_i) begin
          if (cont_q && cfg_cont_i && !stop_pend_q && !cfg_stop_i) begin
            state_d    = GATE;
            gate_cnt_d = '0;
            run_cnt_d  = '0;
            acc_sig_d  = '0;
            acc_ref_d  = '0;
          end else begin
            state_d     = IDLE;
            stop_pend_d = 1'b0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // All outputs come straight from registers, so they hold steady while valid.
  assign meas_gate_en_o = (state_q == GATE);
  assign res_valid_o    = (state_q == OUT);
  assign busy_o         = (state_q != IDLE);
  assign timeout_o      = timeout_q;
  assign res_sig_o      = acc_sig_q;
  assign res_ref_o      = acc_ref_q;
  assign res_runs_o     = run_cnt_q;

endmodule

// File: doc/measure_seq.md
Name: measure_seq

Overview:
- Run controller for the frequency-measurement datapath.
- Drives that datapath's gate enable for a programmed number of clk_i cycles and waits for its 64-bit result pulse {ref_sum, sig_sum}.
- Accumulates results over N runs and presents the summed result on a valid/ready port to the register/AXI layer.
- Supports one-shot and continuous modes, abort, and a result-timeout for an absent input signal.

Parameters:
- CNT_W, 32, width of each sum field in the measurement result.
- RUN_W, 8, width of the run counter; supports 1..2^RUN_W-1 runs.
- ACC_W, CNT_W+RUN_W, accumulator width; overflow is impossible by construction.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- cfg_start_i  in  1  one-cycle start pulse.
- cfg_stop_i  in  1  one-cycle abort pulse.
- cfg_cont_i  in  1  continuous mode; sampled at start and at each result handshake.
- cfg_gate_time_i  in  32  gate length in clk_i cycles; 0 is treated as 1.
- cfg_runs_i  in  RUN_W  runs per result; 0 is treated as 1.
- cfg_timeout_i  in  32  maximum wait for a result after gate close; 0 disables the timeout.
- meas_gate_en_o  out  1  gate level to the measurement datapath.
- meas_wr_en_i  in  1  result strobe from the datapath.
- meas_wr_data_i  in  2*CNT_W  {ref_sum[63:32], sig_sum[31:0]}.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  result accepted.
- res_sig_o  out  ACC_W  accumulated sig_sum.
- res_ref_o  out  ACC_W  accumulated ref_sum.
- res_runs_o  out  RUN_W  number of runs accumulated.
- busy_o  out  1  state != IDLE.
- timeout_o  out  1  sticky timeout flag; cleared by an accepted start.

Behaviour:
- Reset (rst_i=1 at a clk_i edge): state=IDLE; all outputs 0; accumulators, counters and latched cfg cleared.
- The start cycle latches gate time, runs, timeout and cont. Later cfg changes take effect only at the next start.
- States and transitions:
  - IDLE: start and !stop -> GATE, clear acc/run_cnt/timeout_o. Start and stop in the same cycle: stay IDLE.
  - GATE: meas_gate_en_o=1 for exactly G cycles (G = latched gate time, min 1); gate_cnt runs 0..G-1. Then -> WAIT_RES with gate_en low and to_cnt=0.
  - WAIT_RES:
    - meas_wr_en_i -> acc_sig += zero-extended [31:0], acc_ref += zero-extended [63:32], run_cnt++.
    - If run_cnt+1 == runs -> OUT, else -> GATE. The gate re-asserts on the next cycle.
    - to_cnt reaching the latched timeout (when nonzero) -> timeout_o=1, acc discarded, -> IDLE.
    - Strobe and timeout in the same cycle: the strobe wins.
  - OUT:
    - res_valid_o=1; outputs are registered and stable while valid.
    - On res_ready_i: if cont and no stop is pending -> GATE with acc cleared; else -> IDLE.
    - Valid never drops without ready.
- Latency:
  - Start at cycle t: gate high during t+1..t+G.
  - Final strobe at cycle r: res_valid_o at r+1.
  - Ready at cycle h (cont): gate high again at h+1.
- Stop handling:
  - In GATE or WAIT_RES: gate low and state IDLE on the next cycle; acc discarded; no result issued.
  - In OUT: sets stop_pending; the block goes to IDLE after the handshake.
- Strobes in IDLE, GATE or OUT are ignored. A late strobe after an abort must not corrupt the next run.
- Start while busy is ignored.
- Backpressure: in continuous mode no new gate opens until the result handshake completes; no result is ever dropped.
- Arithmetic: counters are unsigned and never wrap. gate_cnt and to_cnt are 32-bit compares; the accumulators cannot overflow.

Decomposition:
- Shared package measure_pkg holds:
  - state enum seq_state_t {IDLE, GATE, WAIT_RES, OUT}
  - CNT_W
  - result field slice constants SIG_LSB=0, REF_LSB=32
- No sub-module: the counters and accumulators are inline.
- The measurement datapath stays a separate instance, wired at the top level.

Test Plan:
- gate_time=100, runs=1, one-shot; model strobe at gate close+6 with data {32'd5000, 32'd1234} -> gate high exactly 100 cycles; res_sig=1234, res_ref=5000, res_runs=1; then IDLE, busy_o=0.
- runs=4, sig sums 10/20/30/40, ref sums 1000 each -> 4 gate pulses; single result res_sig=100, res_ref=4000, res_runs=4.
- Continuous mode, res_ready held low 50 cycles -> valid and data stable for 50 cycles; no gate during the wait; gate re-asserts the cycle after ready.
- timeout=20, no strobe -> timeout_o=1 exactly 20 cycles after gate close; IDLE; no valid; the next start clears timeout_o.
- Stop mid-GATE at cycle 30 of 100 -> gate low next cycle; IDLE; a stray strobe afterwards is ignored. Stop during OUT in cont mode -> IDLE after the handshake.
- rst_i asserted mid-WAIT_RES; gate_time=0 and runs=0 -> all outputs 0 after reset; a 1-cycle gate and a 1-run result respectively.
